// File: rtl/wallace_mac_acc.sv
// wallace_mac_acc
// ----------------------------------------------------------------------------
// Accumulate stage that sits behind the 4x4 Wallace tree multiplier. It takes
// one unsigned 8-bit product per input handshake, sums N_TERMS of them into
// one dot-product result, and keeps that result in a single registered output
// buffer. The buffer applies backpressure to the product source.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous abort of the partial accumulation
//   in_valid   product beat valid
//   in_ready   stage can accept a product this cycle (combinational)
//   in_prod    unsigned product p[7:0] from the multiplier
//   out_valid  result held in the output register
//   out_ready  consumer accepts the result
//   out_sum    accumulated result, clipped to 2^ACC_W-1
//   out_sat    result was clipped to the maximum value
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A source holding valid keeps its data stable until that edge. The
// sink's ready may depend combinationally on its own state and on the
// consumer's out_ready. out_valid is registered. Once raised, it stays high
// with stable data until out_ready is seen.
//
// State view: IDLE  = (cnt == 0 && !out_valid)
//             ACCUM = (cnt != 0)
//             HOLD  = (out_valid && !out_ready)
// ----------------------------------------------------------------------------
module wallace_mac_acc #(
  parameter int ACC_W   = 16,
  parameter int N_TERMS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat
);

  localparam int CNT_W = $clog2(N_TERMS);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_acc_q, sat_acc_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_sat_q, out_sat_d;

  logic             hold;
  logic             acc_fire;
  logic             last_beat;
  logic [ACC_W:0]   nxt;
  logic [ACC_W-1:0] clip;
  logic             sat_nxt;

  always_comb begin
    // A pending result with no taker blocks new beats. A draining result
    // does not, so a beat can be accepted in the same cycle the result leaves.
    hold      = out_valid_q && !out_ready;
    in_ready  = !hold && !clr;
    acc_fire  = in_valid && in_ready;
    last_beat = (cnt_q == CNT_W'(N_TERMS - 1));

    // One extra bit holds the carry. acc is at most 2^ACC_W-1 and a product
    // is at most 255, so the top bit is set exactly when the sum overflows.
    nxt = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, in_prod};
    if (nxt[ACC_W]) begin
      clip    = '1;
      sat_nxt = 1'b1;
    end else begin
      clip    = nxt[ACC_W-1:0];
      sat_nxt = sat_acc_q;
    end

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_acc_d   = sat_acc_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;

    // The drain is applied first. A final beat in the same cycle then
    // re-asserts out_valid with the new result, which replaces the old one
    // with no bubble.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clr) begin
      acc_d     = '0;
      cnt_d     = '0;
      sat_acc_d = 1'b0;
    end else if (acc_fire) begin
      if (last_beat) begin
        out_sum_d   = clip;
        out_sat_d   = sat_nxt;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        sat_acc_d   = 1'b0;
      end else begin
        acc_d     = clip;
        sat_acc_d = sat_nxt;
        cnt_d     = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_acc_q   <= sat_acc_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_wallace_mac_acc.sv
// Directed bench for wallace_mac_acc. One instance uses the default parameters
// (ACC_W=16, N_TERMS=4). A second instance uses ACC_W=10, N_TERMS=8 for the
// saturation cases. Inputs change 1 time unit after a rising edge. Outputs are
// sampled at that same point, away from the active edge.
module tb_wallace_mac_acc;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default instance
  logic        clr, in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [7:0]  in_prod;
  logic [15:0] out_sum;

  // saturation instance
  logic        s_clr, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_sat;
  logic [7:0]  s_in_prod;
  logic [9:0]  s_out_sum;

  int errors = 0;
  int checks = 0;

  wallace_mac_acc dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_sat(out_sat)
  );

  wallace_mac_acc #(.ACC_W(10), .N_TERMS(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .clr(s_clr),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_prod(s_in_prod),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sum(s_out_sum), .out_sat(s_out_sat)
  );

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one product and wait (bounded) until it is accepted on a rising edge.
  task automatic beat(input bit use_s, input logic [7:0] p);
    int waited;
    waited = 0;
    if (use_s) begin s_in_valid = 1'b1; s_in_prod = p; end
    else       begin in_valid   = 1'b1; in_prod   = p; end
    #0;
    while (!(use_s ? s_in_ready : in_ready) && waited < 50) begin
      step();
      waited++;
    end
    if (waited >= 50) check_eq("beat_ready_timeout", 32'd0, 32'd1);
    step();
    if (use_s) s_in_valid = 1'b0;
    else       in_valid   = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    time t0;
    rst_n = 1'b0;
    clr = 1'b0; in_valid = 1'b0; in_prod = 8'd0; out_ready = 1'b0;
    s_clr = 1'b0; s_in_valid = 1'b0; s_in_prod = 8'd0; s_out_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // reset state
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_sum", out_sum, 0);
    check_eq("rst_out_sat", out_sat, 0);
    check_eq("rst_in_ready", in_ready, 1);

    // basic: 225 + 12 + 0 + 1 = 238
    out_ready = 1'b1;
    beat(0, 8'd225); beat(0, 8'd12); beat(0, 8'd0);
    check_eq("basic_not_early", out_valid, 0);
    beat(0, 8'd1);
    check_eq("basic_valid", out_valid, 1);
    check_eq("basic_sum", out_sum, 238);
    check_eq("basic_sat", out_sat, 0);
    step();
    check_eq("basic_drained", out_valid, 0);
    check_eq("basic_sum_held", out_sum, 238);

    // backpressure: 10+20+30+40 = 100 held for 5 cycles
    out_ready = 1'b0;
    beat(0, 8'd10); beat(0, 8'd20); beat(0, 8'd30); beat(0, 8'd40);
    check_eq("bp_valid", out_valid, 1);
    check_eq("bp_sum", out_sum, 100);
    in_valid = 1'b1; in_prod = 8'd77;  // ignored while stalled
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_sum_stable", out_sum, 100);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", in_ready, 1);
    beat(0, 8'd5);  // drain and accept on the same edge
    check_eq("bp_drain_with_accept", out_valid, 0);
    beat(0, 8'd5); beat(0, 8'd5); beat(0, 8'd5);
    check_eq("bp_next_valid", out_valid, 1);
    check_eq("bp_next_sum", out_sum, 20);

    // back-to-back: 8 beats of 2, continuous
    t0 = $time;
    for (int i = 0; i < 8; i++) begin
      beat(0, 8'd2);
      if (i == 3 || i == 7) begin
        check_eq("b2b_valid", out_valid, 1);
        check_eq("b2b_sum", out_sum, 8);
      end
      if (i == 4) check_eq("b2b_drained", out_valid, 0);
    end
    check_eq("b2b_cycles", 32'(($time - t0) / 10), 8);

    // clr mid-set: 20 + 30 discarded, then 4 x 10 = 40
    beat(0, 8'd20); beat(0, 8'd30);
    in_valid = 1'b1; in_prod = 8'd99; clr = 1'b1;
    #1;
    check_eq("clr_in_ready", in_ready, 0);
    step();
    clr = 1'b0; in_valid = 1'b0;
    beat(0, 8'd10); beat(0, 8'd10); beat(0, 8'd10);
    check_eq("clr_not_early", out_valid, 0);
    beat(0, 8'd10);
    check_eq("clr_valid", out_valid, 1);
    check_eq("clr_sum", out_sum, 40);

    // saturation, ACC_W=10 N_TERMS=8: 8 x 225 = 1800 -> 1023
    s_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) beat(1, 8'd225);
    check_eq("sat_valid", s_out_valid, 1);
    check_eq("sat_sum", s_out_sum, 1023);
    check_eq("sat_flag", s_out_sat, 1);
    for (int i = 0; i < 8; i++) beat(1, 8'd1);
    check_eq("sat2_valid", s_out_valid, 1);
    check_eq("sat2_sum", s_out_sum, 8);
    check_eq("sat2_flag", s_out_sat, 0);

    // async reset mid-set: out_sum 40 is held, then 3 beats, then reset
    beat(0, 8'd1); beat(0, 8'd1); beat(0, 8'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_out_sum", out_sum, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    beat(0, 8'd1); beat(0, 8'd1); beat(0, 8'd1);
    check_eq("arst_not_early", out_valid, 0);
    beat(0, 8'd1);
    check_eq("arst_valid", out_valid, 1);
    check_eq("arst_sum", out_sum, 4);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
